// File: rtl/rambam_if.sv
// Valid/ready handshake bundle for the RAMBAM decoder: redundant value in, field element out.
interface rambam_if #(
    parameter int d = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [7+d:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/rambam_decoder.sv
// Reduces an (8+d)-bit RAMBAM redundant value modulo P, one redundant bit per
// cycle from the top down, and hands back the plain GF(2^8) element.
module rambam_decoder #(
    parameter int         d = 4,
    parameter logic [8:0] P = 9'h11B
) (
    input  logic     clk,
    input  logic     rst,
    rambam_if.slave  bus
);
    localparam int DW = 8 + d;
    localparam int CW = (d > 1) ? $clog2(d) : 1;
    localparam logic [DW-1:0] PW  = DW'(P);
    localparam logic [DW-1:0] TOP = DW'(256);

    if (d < 1) begin : g_bad_d
        $error("rambam_decoder: d must be >= 1");
    end
    if (P[8] != 1'b1) begin : g_bad_p
        $error("rambam_decoder: P must be monic of degree 8");
    end

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] k_q, k_d;
    logic [7:0]    out_q, out_d;
    logic [DW-1:0] red;

    // P and the bit it cancels both sit k positions up from their degree-8 home
    always_comb begin
        red = acc_q;
        if ((acc_q & (TOP << k_q)) != '0) red = acc_q ^ (PW << k_q);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        k_d     = k_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d   = bus.in_data;
                    k_d     = CW'(d - 1);
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                acc_d = red;
                if (k_q == '0) begin
                    out_d   = red[7:0];
                    state_d = DONE;
                end else begin
                    k_d = k_q - CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            out_q   <= out_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_q;
endmodule
